// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM controller.
//   - SDRAM command encodings, {CS, RAS, CAS, WE}
//   - arbiter state encoding
//   - default refresh interval and a counter-width helper
package sdram_pkg;

  // SDRAM commands, {CS, RAS, CAS, WE}
  localparam logic [3:0] CmdNop       = 4'b0111;
  localparam logic [3:0] CmdPrecharge = 4'b0010;
  localparam logic [3:0] CmdAutoRef   = 4'b0001;
  localparam logic [3:0] CmdMrset     = 4'b0000;
  localparam logic [3:0] CmdActive    = 4'b0011;
  localparam logic [3:0] CmdWrite     = 4'b0100;
  localparam logic [3:0] CmdRead      = 4'b0101;

  // Refresh interval in sclk cycles: 15 us at 50 MHz
  localparam int unsigned RefCntDefault = 750;

  // Binary-encoded arbiter states
  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StArbit = 3'd1,
    StAref  = 3'd2,
    StWrite = 3'd3,
    StRead  = 3'd4
  } arb_state_e;

  // Width of a counter that must hold 0..n-1 (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: periodic auto-refresh request generator.
//   sclk        in   system clock
//   s_rst_n     in   asynchronous active-low reset
//   init_done   in   pulse marking the end of power-up init; starts the timer
//   ref_ack     in   refresh grant; clears the pending request
//   ref_pending out  a refresh is due and has not yet been granted
// The counter stays at 0 until init_done, then free-runs 0..REF_CNT-1.
// Requests do not queue: a second wrap while pending leaves it set.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int unsigned REF_CNT = RefCntDefault
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic init_done,
  input  logic ref_ack,
  output logic ref_pending
);

  localparam int unsigned CntW = cnt_width(REF_CNT);
  localparam logic [CntW-1:0] CntMax = CntW'(REF_CNT - 1);

  logic            running_q;
  logic [CntW-1:0] cnt_q;
  logic            pending_q;
  logic            wrap;

  assign wrap = running_q && (cnt_q == CntMax);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      if (init_done) begin
        running_q <= 1'b1;
      end
      if (running_q) begin
        cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      end
      // A fresh expiry takes precedence over an acknowledge in the same cycle
      if (wrap) begin
        pending_q <= 1'b1;
      end else if (ref_ack) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign ref_pending = pending_q;

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants the SDRAM command bus to one sub-block at a time.
//   sclk, s_rst_n                  clock, asynchronous active-low reset
//   init_cmd/addr/bank, init_end   power-up init block bus and completion pulse
//   aref_cmd/addr, aref_end        auto-refresh block bus and completion pulse
//   aref_en                        one-cycle refresh start pulse
//   wr_req, wr_cmd/addr/bank, wr_end, wr_en   write block request/bus/done/grant
//   rd_req, rd_cmd/addr/bank, rd_end, rd_en   read block request/bus/done/grant
//   sdram_cmd/addr/bank            SDRAM pins
// Init runs first; afterwards refresh beats write, write beats read.
// The pin mux depends only on the registered state, so a granted block's
// registered outputs reach the pins with no added latency.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned REF_CNT = RefCntDefault
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  // init block
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic [1:0]  init_bank,
  input  logic        init_end,
  // auto-refresh block
  input  logic [3:0]  aref_cmd,
  input  logic [11:0] aref_addr,
  input  logic        aref_end,
  output logic        aref_en,
  // write block
  input  logic        wr_req,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        wr_end,
  output logic        wr_en,
  // read block
  input  logic        rd_req,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  input  logic        rd_end,
  output logic        rd_en,
  // SDRAM pins
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank
);

  arb_state_e state_q;
  logic       ref_pending;
  logic       ref_grant;
  logic       init_done;

  // Refresh is granted in the same cycle the state register loads StAref,
  // so the pending flag clears on that edge as well.
  assign ref_grant = (state_q == StArbit) && ref_pending;
  assign init_done = (state_q == StInit) && init_end;

  sdram_ref_timer #(
    .REF_CNT (REF_CNT)
  ) u_ref_timer (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .init_done   (init_done),
    .ref_ack     (ref_grant),
    .ref_pending (ref_pending)
  );

  // State and registered grant pulses
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= StInit;
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
    end else begin
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      unique case (state_q)
        StInit: begin
          if (init_end) begin
            state_q <= StArbit;
          end
        end
        StArbit: begin
          if (ref_pending) begin
            state_q <= StAref;
            aref_en <= 1'b1;
          end else if (wr_req) begin
            state_q <= StWrite;
            wr_en   <= 1'b1;
          end else if (rd_req) begin
            state_q <= StRead;
            rd_en   <= 1'b1;
          end
        end
        // Only the granted block's end pulse returns control
        StAref: begin
          if (aref_end) begin
            state_q <= StArbit;
          end
        end
        StWrite: begin
          if (wr_end) begin
            state_q <= StArbit;
          end
        end
        StRead: begin
          if (rd_end) begin
            state_q <= StArbit;
          end
        end
        default: begin
          state_q <= StInit;
        end
      endcase
    end
  end

  // Pin mux; StArbit (and any illegal state) drives NOP
  always_comb begin
    sdram_cmd  = CmdNop;
    sdram_addr = '0;
    sdram_bank = '0;
    unique case (state_q)
      StInit: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
        sdram_bank = init_bank;
      end
      StAref: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      StWrite: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      StRead: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: begin
        sdram_cmd  = CmdNop;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed test of the SDRAM command arbiter with a small
// grant scoreboard. Each sub-block drives a distinct constant bus so the pin
// value identifies which source the arbiter selected.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int unsigned RefCnt = 16;

  localparam int GAref = 0;
  localparam int GWr   = 1;
  localparam int GRd   = 2;

  localparam logic [17:0] BusInit = {CmdMrset,   12'h111, 2'd1};
  localparam logic [17:0] BusAref = {CmdAutoRef, 12'h222, 2'd0};
  localparam logic [17:0] BusWr   = {CmdWrite,   12'h333, 2'd2};
  localparam logic [17:0] BusRd   = {CmdRead,    12'h444, 2'd3};
  localparam logic [17:0] BusNop  = {CmdNop,     12'h000, 2'd0};

  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic [3:0]  init_cmd;
  logic [11:0] init_addr;
  logic [1:0]  init_bank;
  logic        init_end = 1'b0;
  logic [3:0]  aref_cmd;
  logic [11:0] aref_addr;
  logic        aref_end = 1'b0;
  logic        aref_en;
  logic        wr_req = 1'b0;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  wr_bank;
  logic        wr_end = 1'b0;
  logic        wr_en;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank;
  logic        rd_end = 1'b0;
  logic        rd_en;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;

  logic [17:0] bus;
  logic [2:0]  ens;
  assign bus = {sdram_cmd, sdram_addr, sdram_bank};
  assign ens = {aref_en, wr_en, rd_en};

  sdram_arbiter #(
    .REF_CNT (RefCnt)
  ) dut (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .init_cmd   (init_cmd),
    .init_addr  (init_addr),
    .init_bank  (init_bank),
    .init_end   (init_end),
    .aref_cmd   (aref_cmd),
    .aref_addr  (aref_addr),
    .aref_end   (aref_end),
    .aref_en    (aref_en),
    .wr_req     (wr_req),
    .wr_cmd     (wr_cmd),
    .wr_addr    (wr_addr),
    .wr_bank    (wr_bank),
    .wr_end     (wr_end),
    .wr_en      (wr_en),
    .rd_req     (rd_req),
    .rd_cmd     (rd_cmd),
    .rd_addr    (rd_addr),
    .rd_bank    (rd_bank),
    .rd_end     (rd_end),
    .rd_en      (rd_en),
    .sdram_cmd  (sdram_cmd),
    .sdram_addr (sdram_addr),
    .sdram_bank (sdram_bank)
  );

  always #5 sclk = ~sclk;

  // Edge counter; after "@(posedge sclk); #1" it equals the edges seen so far
  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } grant_t;

  grant_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [17:0] bus_of(input int kind);
    case (kind)
      GAref:   return BusAref;
      GWr:     return BusWr;
      default: return BusRd;
    endcase
  endfunction

  function automatic logic [2:0] en_of(input int kind);
    case (kind)
      GAref:   return 3'b100;
      GWr:     return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step(1);
  endtask

  // End pulse of the given block, sampled by the DUT on edge k
  task automatic pulse_end(input int kind, input int k);
    step_to(k - 1);
    case (kind)
      GAref:   aref_end = 1'b1;
      GWr:     wr_end   = 1'b1;
      default: rd_end   = 1'b1;
    endcase
    step(1);
    aref_end = 1'b0;
    wr_end   = 1'b0;
    rd_end   = 1'b0;
  endtask

  // Pop the next expected grant and compare it with the next grant pulse
  task automatic wait_grant();
    grant_t e;
    int n;
    e = exp_q.pop_front();
    n = 0;
    while (ens == 3'b000 && n < 200) begin
      step(1);
      n++;
    end
    check("grant_kind", 32'(ens), 32'(en_of(e.kind)));
    check("grant_cycle", cyc, e.at);
    check("grant_bus", 32'(bus), 32'(bus_of(e.kind)));
    step(1);
    check("grant_one_cycle", 32'(ens), 32'd0);
    check("grant_bus_hold", 32'(bus), 32'(bus_of(e.kind)));
  endtask

  initial begin
    logic [2:0] acc;
    {init_cmd, init_addr, init_bank} = BusInit;
    {aref_cmd, aref_addr}            = BusAref[17:2];
    {wr_cmd, wr_addr, wr_bank}       = BusWr;
    {rd_cmd, rd_addr, rd_bank}       = BusRd;

    // Reset state
    step(3);
    check("reset_bus", 32'(bus), 32'(BusInit));
    check("reset_en", 32'(ens), 32'd0);
    s_rst_n = 1'b1;

    // Init completes on edge 20
    step_to(19);
    check("init_hold_bus", 32'(bus), 32'(BusInit));
    check("init_hold_en", 32'(ens), 32'd0);
    init_end = 1'b1;
    step(1);
    init_end = 1'b0;
    check("arbit_nop", 32'(bus), 32'(BusNop));
    check("arbit_no_en", 32'(ens), 32'd0);

    // Refresh: timer runs from edge 20; first expiry on 36, grant on 37
    exp_q.push_back('{GAref, 37});
    wait_grant();
    pulse_end(GAref, 41);
    check("aref_done_nop", 32'(bus), 32'(BusNop));
    exp_q.push_back('{GAref, 53});
    wait_grant();

    // Contention: both requests waiting when refresh finishes
    wr_req = 1'b1;
    rd_req = 1'b1;
    pulse_end(GAref, 55);
    check("contend_nop", 32'(bus), 32'(BusNop));
    exp_q.push_back('{GWr, 56});
    wait_grant();

    // Stray read end during a write burst
    pulse_end(GRd, 60);
    check("stray_bus", 32'(bus), 32'(BusWr));
    check("stray_en", 32'(ens), 32'd0);

    // Refresh due at edge 68 preempts the still-requesting writer
    pulse_end(GWr, 70);
    check("wr_end_nop", 32'(bus), 32'(BusNop));
    exp_q.push_back('{GAref, 71});
    wait_grant();
    pulse_end(GAref, 73);
    exp_q.push_back('{GWr, 74});
    wait_grant();
    wr_req = 1'b0;

    // Read follows two cycles after the write's end pulse
    pulse_end(GWr, 77);
    check("wr_end2_nop", 32'(bus), 32'(BusNop));
    exp_q.push_back('{GRd, 78});
    wait_grant();

    // Reset mid-read with a refresh pending (expired on edge 84)
    step_to(85);
    s_rst_n = 1'b0;
    rd_req  = 1'b0;
    #1;
    check("rst_mid_bus", 32'(bus), 32'(BusInit));
    check("rst_mid_en", 32'(ens), 32'd0);
    step(2);
    s_rst_n = 1'b1;

    // Nothing may be granted before a fresh init_end
    acc = 3'b000;
    while (cyc < 119) begin
      if (cyc == 110) wr_req = 1'b1;
      step(1);
      acc = acc | ens;
    end
    check("reinit_no_grant", 32'(acc), 32'd0);
    check("reinit_bus", 32'(bus), 32'(BusInit));

    // init_end with wr_req: ARBIT first, write one cycle later
    init_end = 1'b1;
    step(1);
    init_end = 1'b0;
    check("reinit_nop", 32'(bus), 32'(BusNop));
    exp_q.push_back('{GWr, 121});
    wait_grant();
    wr_req = 1'b0;
    pulse_end(GWr, 124);

    // Counter restarted from 0 on edge 120 with no stale pending request
    exp_q.push_back('{GAref, 137});
    wait_grant();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d expected finish before cycle 10000", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Central command arbiter for the SDRAM controller. It sits between the command-generating sub-blocks (power-up initialisation, auto-refresh, write burst, read burst) and the SDRAM pins, and grants exactly one sub-block at a time. It owns the periodic refresh timer and drives the shared command/address/bank bus. Init runs first and unconditionally; after that, refresh takes priority over write, and write takes priority over read.

## Interface
- REF_CNT, 750: refresh interval in sclk cycles (15 us at 50 MHz)
- sclk  in  1  system clock; all logic rising-edge
- s_rst_n  in  1  asynchronous active-low reset
- init_cmd  in  4  init command {CS,RAS,CAS,WE}
- init_addr  in  12  init address
- init_bank  in  2  init bank
- init_end  in  1  one-cycle pulse, init sequence complete
- aref_cmd / aref_addr  in  4 / 12  refresh block command, address
- aref_end  in  1  one-cycle pulse, refresh done
- aref_en  out  1  one-cycle start pulse to refresh block
- wr_req  in  1  level, write block has a burst pending
- wr_cmd / wr_addr / wr_bank  in  4 / 12 / 2  write block bus
- wr_end  in  1  one-cycle pulse, write burst done
- wr_en  out  1  one-cycle grant pulse to write block
- rd_req, rd_cmd, rd_addr, rd_bank, rd_end  in  1/4/12/2/1  read block, same semantics as write
- rd_en  out  1  one-cycle grant pulse to read block
- sdram_cmd  out  4  command to SDRAM pins
- sdram_addr  out  12  address to SDRAM pins
- sdram_bank  out  2  bank to SDRAM pins

## Operation
- States: INIT, ARBIT, AREF, WRITE, READ. State is one-hot or binary; the encoding lives in the package.
- INIT: the bus is muxed from init_*. On init_end, go to ARBIT.
- ARBIT: the bus drives NOP (4'b0111), with addr 0 and bank 0. Priority is evaluated every cycle:
  - ref_pending: assert aref_en, go to AREF.
  - else wr_req: assert wr_en, go to WRITE.
  - else rd_req: assert rd_en, go to READ.
  - else stay in ARBIT.
- AREF, WRITE, READ: the bus is muxed from the granted block. On that block's *_end, go to ARBIT. *_end from a non-granted block is ignored.
- Refresh timer:
  - Held at 0 until init_end is seen.
  - Then counts 0..REF_CNT-1 and wraps to 0, free-running.
  - At count REF_CNT-1, ref_pending is set.
  - ref_pending is cleared in the same cycle aref_en is asserted.
  - If the timer reaches REF_CNT-1 again while ref_pending is still set, ref_pending stays 1. Requests do not queue.
- Fixed priority: read may be starved by continuous wr_req. This is intentional; the write block de-asserts wr_req between bursts.
- wr_req or rd_req asserted outside ARBIT is held by the requester. The arbiter does not latch them.

## Timing
- Reset values:
  - state = INIT
  - aref_en = wr_en = rd_en = 0
  - refresh counter = 0, ref_pending = 0
  - sdram_* follow the INIT mux, i.e. init_* values, which are NOP after reset.
- *_en is a registered output. It is high for exactly the one cycle in which the state register loads AREF/WRITE/READ, i.e. the first cycle in the new state.
- Bus mux is combinational on the registered state. Zero added latency from a sub-block's registered outputs to the pins.
- *_end in cycle N: state = ARBIT in N+1. The earliest next grant is visible in N+2. There is a minimum of one NOP cycle between bursts.
- wr_end coincident with ref_pending being set: ARBIT next cycle, then AREF. Refresh wins over a waiting wr_req.
- init_end coincident with wr_req: ARBIT first; the write is granted one cycle later.
- Reset asserted mid-burst: immediate return to INIT. Grants and ref_pending are cleared. The counter is held until a fresh init_end.

## Structure
- Package sdram_pkg holds:
  - command encodings NOP=4'b0111, PRECHARGE=4'b0010, AUTO_REF=4'b0001, MRSET=4'b0000, ACTIVE=4'b0011, WRITE=4'b0100, READ=4'b0101
  - the arbiter state encoding
  - default REF_CNT
- Sub-module sdram_ref_timer: holds the counter and ref_pending, with inputs init_done and ref_ack (= aref_en).
- The top contains the FSM, the grant pulses and the output mux.

## Test plan
- Reset then init: init_end at cycle 20, no requests → state ARBIT from cycle 21 with sdram_cmd=0111; no *_en.
- Refresh period with REF_CNT=16: init_end, idle → aref_en pulses 16 cycles after the counter starts. With aref_end 4 cycles later, the next aref_en follows 16 cycles after the first.
- Contention: wr_req and rd_req high together in ARBIT → wr_en pulse, sdram_* = wr_*. After wr_end and wr_req low, rd_en is asserted 2 cycles after wr_end.
- Refresh preemption: ref_pending set during WRITE, wr_req still high → on wr_end, aref_en is granted before the second wr_en.
- Stray end: rd_end pulsed during WRITE → no state change, bus stays wr_*.
- Reset mid-READ: s_rst_n low for 2 cycles → state INIT, rd_en=0, ref_pending=0; the counter does not run until a new init_end.
